// File: rtl/dlfloat_div.sv
// DLfloat16 sequential divider c = a / b using a 12-step restoring mantissa divide.
// Latency: 13 cycles from accept to out_valid, including special operands.
// Backpressure: in_ready is low while busy; the result is held stable in DONE until out_ready.
// Optional feature: define DLFLOAT_DIV_RNE_EN for round-to-nearest-even (default truncates).
module dlfloat_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        flag_dz,
  output logic        flag_nv
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t           state_q, state_d;
  special_t         sp_q, sp_d;
  logic             dz_pend_q, dz_pend_d;
  logic             sign_q;
  logic [9:0]       mb_q;
  logic [10:0]      r_q, r_d;
  logic [11:0]      q_q, q_d;
  logic [3:0]       count_q;
  logic signed [7:0] ediff_q;
  logic [15:0]      c_q, c_d;
  logic             dz_q, nv_q;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic r_ge;
  logic [9:0] r_sub;

  assign a_zero = (a[14:9] == 6'd0);
  assign b_zero = (b[14:9] == 6'd0);
  assign a_inf  = (a[14:9] == 6'h3F) && (a[8:0] == 9'd0);
  assign b_inf  = (b[14:9] == 6'h3F) && (b[8:0] == 9'd0);
  assign a_nan  = (a[14:9] == 6'h3F) && (a[8:0] != 9'd0);
  assign b_nan  = (b[14:9] == 6'h3F) && (b[8:0] != 9'd0);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign flag_dz   = dz_q;
  assign flag_nv   = nv_q;

  // Classify operands at accept time; first matching rule wins.
  always_comb begin
    sp_d      = SP_NONE;
    dz_pend_d = 1'b0;
    if (a_nan || b_nan)                          sp_d = SP_NAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) sp_d = SP_NAN;
    else if (a_inf)                              sp_d = SP_INF;
    else if (b_zero) begin
      sp_d      = SP_INF;
      dz_pend_d = 1'b1;
    end
    else if (a_zero || b_inf)                    sp_d = SP_ZERO;
  end

  // One restoring step: subtract divisor when it fits, shift remainder left.
  always_comb begin
    r_ge  = (r_q >= {1'b0, mb_q});
    r_sub = r_ge ? 10'(r_q - {1'b0, mb_q}) : r_q[9:0];
    r_d   = {r_sub, 1'b0};
    q_d   = {q_q[10:0], r_ge};
  end

  // Normalise, round, range-check and apply special overrides to form the result.
  always_comb begin
    logic [8:0]        mant_n, mant_r;
    logic signed [7:0] e_n, e_r;
`ifdef DLFLOAT_DIV_RNE_EN
    logic       guard_n, sticky_n, round_up;
    logic [9:0] mant_inc;
`endif
    if (q_q[11]) begin
      mant_n = q_q[10:2];
      e_n    = ediff_q;
    end else begin
      mant_n = q_q[9:1];
      e_n    = ediff_q - 8'sd1;
    end
`ifdef DLFLOAT_DIV_RNE_EN
    guard_n  = q_q[11] ? q_q[1] : q_q[0];
    sticky_n = (q_q[11] & q_q[0]) | (r_q != 11'd0);
    round_up = guard_n & (sticky_n | mant_n[0]);
    mant_inc = {1'b0, mant_n} + {9'd0, round_up};
    mant_r   = mant_inc[8:0];
    e_r      = mant_inc[9] ? e_n + 8'sd1 : e_n;
`else
    mant_r   = mant_n;
    e_r      = e_n;
`endif
    if (e_r <= 8'sd0)       c_d = {sign_q, 15'd0};
    else if (e_r >= 8'sd63) c_d = {sign_q, 6'h3F, 9'd0};
    else                    c_d = {sign_q, e_r[5:0], mant_r};
    case (sp_q)
      SP_NAN:  c_d = 16'h7FFF;
      SP_INF:  c_d = {sign_q, 6'h3F, 9'd0};
      SP_ZERO: c_d = {sign_q, 15'd0};
      default: ;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept, 12 divide steps, normalise, then hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_DIV;
      S_DIV:  if (count_q == 4'd11) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration, and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q      <= SP_NONE;
      dz_pend_q <= 1'b0;
      sign_q    <= 1'b0;
      mb_q      <= 10'd0;
      r_q       <= 11'd0;
      q_q       <= 12'd0;
      count_q   <= 4'd0;
      ediff_q   <= 8'sd0;
      c_q       <= 16'h0000;
      dz_q      <= 1'b0;
      nv_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sp_q      <= sp_d;
          dz_pend_q <= dz_pend_d;
          sign_q    <= a[15] ^ b[15];
          mb_q      <= {1'b1, b[8:0]};
          r_q       <= {2'b01, a[8:0]};
          q_q       <= 12'd0;
          count_q   <= 4'd0;
          ediff_q   <= $signed({2'b00, a[14:9]}) - $signed({2'b00, b[14:9]}) + 8'sd31;
        end
        S_DIV: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + 4'd1;
        end
        S_NORM: begin
          c_q  <= c_d;
          dz_q <= dz_pend_q;
          nv_q <= (sp_q == SP_NAN);
        end
        default: ;
      endcase
    end
  end

endmodule
